// File: rtl/apb_slv_pkg.sv
// Shared state encodings, response codes and helpers for the APB slave bridge.
package apb_slv_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  // Byte-offset bits that must be zero for a word-aligned access.
  function automatic int unsigned align_mask(input int unsigned data_w);
    return (data_w / 8) - 1;
  endfunction

endpackage

// File: rtl/apb_slv_timeout.sv
// BUSY-cycle watchdog: expired rises during the TIMEOUT-th enabled cycle.
module apb_slv_timeout #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  if (TIMEOUT == 0) begin : g_off
    logic unused;
    assign unused  = ^{clk, rst, clr, en};
    assign expired = 1'b0;
  end else begin : g_on
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (clr) begin
        cnt <= '0;
      end else if (en) begin
        cnt <= cnt + 1'b1;
      end
    end

    // cnt holds completed cycles, so the last allowed cycle sees TIMEOUT-1.
    assign expired = en && (cnt == CW'(TIMEOUT - 1));
  end

endmodule

// File: rtl/apb_slv_bridge.sv
// APB4 slave front-end turning APB transfers into a req/ack handshake toward a register bank.
module apb_slv_bridge
  import apb_slv_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_LIMIT = 32'hFFC,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   apb_paddr_i,
  input  logic                apb_psel_i,
  input  logic                apb_penable_i,
  input  logic                apb_pwrite_i,
  input  logic [DATA_W-1:0]   apb_pwdata_i,
  input  logic [DATA_W/8-1:0] apb_pstrb_i,
  output logic                apb_pready_o,
  output logic [DATA_W-1:0]   apb_prdata_o,
  output logic                apb_pslverr_o,
  output logic                reg_req_o,
  output logic                reg_we_o,
  output logic [ADDR_W-1:0]   reg_addr_o,
  output logic [DATA_W-1:0]   reg_wdata_o,
  output logic [DATA_W/8-1:0] reg_be_o,
  input  logic [DATA_W-1:0]   reg_rdata_i,
  input  logic                reg_ack_i,
  input  logic                reg_err_i,
  output logic                reg_rd_done_o
);

  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(ADDR_LIMIT);
  localparam logic [ADDR_W-1:0] AMASK = ADDR_W'(align_mask(DATA_W));

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic                we;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] be;
  logic [DATA_W-1:0]   rdata;
  logic                err;
  logic                abort;
  logic                rd_done;
  logic                expired;
  logic                setup;
  logic                bad_addr;

  assign setup    = apb_psel_i && !apb_penable_i;
  assign bad_addr = (apb_paddr_i > LIMIT) || ((apb_paddr_i & AMASK) != '0);

  apb_slv_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (state != BUSY),
    .en     (state == BUSY),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr    <= '0;
      we      <= 1'b0;
      wdata   <= '0;
      be      <= '0;
      rdata   <= '0;
      err     <= RESP_OKAY;
      abort   <= 1'b0;
      rd_done <= 1'b0;
    end else begin
      rd_done <= (state == RESP) && !we && (err == RESP_OKAY);
      case (state)
        IDLE: begin
          if (setup) begin
            addr  <= apb_paddr_i;
            we    <= apb_pwrite_i;
            wdata <= apb_pwdata_i;
            be    <= apb_pstrb_i;
            rdata <= '0;
            abort <= 1'b0;
            if (bad_addr) begin
              err   <= RESP_ERR;
              state <= RESP;
            end else if (apb_pwrite_i && (apb_pstrb_i == '0)) begin
              err   <= RESP_OKAY;
              state <= RESP;
            end else begin
              err   <= RESP_OKAY;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (!apb_psel_i) abort <= 1'b1;
          // Ack takes priority over a simultaneous timeout expiry.
          if (reg_ack_i) begin
            err   <= reg_err_i;
            rdata <= we ? '0 : reg_rdata_i;
          end else if (expired) begin
            err   <= RESP_ERR;
            rdata <= '0;
          end
          if (reg_ack_i || expired) begin
            state <= (abort || !apb_psel_i) ? IDLE : RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign apb_pready_o  = (state == RESP);
  assign apb_pslverr_o = (state == RESP) && err;
  assign apb_prdata_o  = (state == RESP) ? rdata : '0;
  assign reg_req_o     = (state == BUSY);
  assign reg_we_o      = we;
  assign reg_addr_o    = addr;
  assign reg_wdata_o   = wdata;
  assign reg_be_o      = be;
  assign reg_rd_done_o = rd_done;

endmodule

// File: tb/tb_apb_slv_bridge.sv
// Directed bench for apb_slv_bridge with 13-bit addresses, 32-bit data and TIMEOUT=16.
module tb_apb_slv_bridge;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] paddr = '0;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic          pwrite = 1'b0;
  logic [DW-1:0] pwdata = '0;
  logic [3:0]    pstrb = '0;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;
  logic          req;
  logic          we;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rwdata;
  logic [3:0]    rbe;
  logic [DW-1:0] rrdata = '0;
  logic          ack = 1'b0;
  logic          rerr = 1'b0;
  logic          rd_done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  apb_slv_bridge #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .ADDR_LIMIT(32'hFFC),
    .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .apb_paddr_i(paddr), .apb_psel_i(psel), .apb_penable_i(penable),
    .apb_pwrite_i(pwrite), .apb_pwdata_i(pwdata), .apb_pstrb_i(pstrb),
    .apb_pready_o(pready), .apb_prdata_o(prdata), .apb_pslverr_o(pslverr),
    .reg_req_o(req), .reg_we_o(we), .reg_addr_o(raddr), .reg_wdata_o(rwdata),
    .reg_be_o(rbe), .reg_rdata_i(rrdata), .reg_ack_i(ack), .reg_err_i(rerr),
    .reg_rd_done_o(rd_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_setup(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d, input logic [3:0] s);
    paddr = a; pwrite = w; pwdata = d; pstrb = s; psel = 1'b1; penable = 1'b0;
  endtask

  task automatic drive_idle();
    psel = 1'b0; penable = 1'b0; ack = 1'b0; rerr = 1'b0; rrdata = '0;
  endtask

  task automatic test_reset();
    step(); step();
    vectors++;
    if ({pready, pslverr, prdata, req, we, raddr, rwdata, rbe, rd_done} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", {pready, pslverr, prdata, req, we, raddr, rwdata, rbe, rd_done});
    end
    rst = 1'b0;
    step();
    vectors++;
    if (req !== 1'b0) begin miscompares++; $display("FAIL reset_release_req: got %b want 0", req); end
  endtask

  task automatic test_read();
    drive_setup(13'h010, 1'b0, '0, 4'b0000);
    step();
    vectors++;
    if ({req, we, raddr} !== {1'b1, 1'b0, 13'h010}) begin miscompares++; $display("FAIL rd_busy: got req=%b we=%b addr=%h want 1 0 010", req, we, raddr); end
    penable = 1'b1; ack = 1'b1; rrdata = 32'hDEADBEEF;
    step();
    vectors++;
    if ({pready, pslverr, prdata, req} !== {1'b1, 1'b0, 32'hDEADBEEF, 1'b0}) begin
      miscompares++; $display("FAIL rd_resp: got pready=%b pslverr=%b prdata=%h req=%b want 1 0 deadbeef 0", pready, pslverr, prdata, req);
    end
    drive_idle();
    step();
    vectors++;
    if ({rd_done, pready} !== 2'b10) begin miscompares++; $display("FAIL rd_done_pulse: got rd_done=%b pready=%b want 1 0", rd_done, pready); end
    step();
    vectors++;
    if (rd_done !== 1'b0) begin miscompares++; $display("FAIL rd_done_width: got %b want 0", rd_done); end
  endtask

  task automatic test_write();
    drive_setup(13'h020, 1'b1, 32'h12345678, 4'b0101);
    step();
    penable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({req, we, rbe, rwdata, pready} !== {1'b1, 1'b1, 4'b0101, 32'h12345678, 1'b0}) begin
        miscompares++; $display("FAIL wr_busy%0d: got req=%b we=%b be=%b wdata=%h pready=%b", i, req, we, rbe, rwdata, pready);
      end
      ack = (i == 2);
      step();
    end
    vectors++;
    if ({pready, pslverr, prdata, req} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      miscompares++; $display("FAIL wr_resp: got pready=%b pslverr=%b prdata=%h req=%b want 1 0 0 0", pready, pslverr, prdata, req);
    end
    drive_idle();
    step();
    vectors++;
    if (rd_done !== 1'b0) begin miscompares++; $display("FAIL wr_no_rd_done: got %b want 0", rd_done); end
  endtask

  task automatic test_addr_checks();
    logic [AW-1:0] bad [2];
    bad[0] = 13'h0FFE;
    bad[1] = 13'h1000;
    for (int i = 0; i < 2; i++) begin
      drive_setup(bad[i], 1'b0, '0, 4'b0000);
      step();
      vectors++;
      if ({pready, pslverr, req, prdata} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
        miscompares++; $display("FAIL addr_err_%h: got pready=%b pslverr=%b req=%b prdata=%h want 1 1 0 0", bad[i], pready, pslverr, req, prdata);
      end
      penable = 1'b1;
      step();
      drive_idle();
      vectors++;
      if ({req, pready, rd_done} !== 3'b000) begin miscompares++; $display("FAIL addr_err_after_%h: got req/pready/rd_done=%b want 000", bad[i], {req, pready, rd_done}); end
    end
    drive_setup(13'h0FFC, 1'b0, '0, 4'b0000);
    step();
    vectors++;
    if ({req, pready} !== 2'b10) begin miscompares++; $display("FAIL addr_limit_ok: got req=%b pready=%b want 1 0", req, pready); end
    penable = 1'b1; ack = 1'b1; rrdata = 32'h0000ABCD;
    step();
    vectors++;
    if ({pslverr, prdata} !== {1'b0, 32'h0000ABCD}) begin miscompares++; $display("FAIL addr_limit_data: got pslverr=%b prdata=%h want 0 0000abcd", pslverr, prdata); end
    drive_idle();
    step();
    drive_setup(13'h030, 1'b1, 32'h55AA55AA, 4'b0000);
    step();
    vectors++;
    if ({pready, pslverr, req} !== 3'b100) begin miscompares++; $display("FAIL zero_strb: got pready=%b pslverr=%b req=%b want 1 0 0", pready, pslverr, req); end
    penable = 1'b1;
    step();
    drive_idle();
    step();
  endtask

  task automatic test_timeout();
    drive_setup(13'h040, 1'b0, '0, 4'b0000);
    step();
    penable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if ({req, pready} !== 2'b10) begin miscompares++; $display("FAIL to_busy%0d: got req=%b pready=%b want 1 0", i, req, pready); end
      step();
    end
    vectors++;
    if ({pready, pslverr, prdata, req} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
      miscompares++; $display("FAIL to_resp: got pready=%b pslverr=%b prdata=%h req=%b want 1 1 0 0", pready, pslverr, prdata, req);
    end
    drive_idle();
    step();
    vectors++;
    if (rd_done !== 1'b0) begin miscompares++; $display("FAIL to_no_rd_done: got %b want 0", rd_done); end
  endtask

  task automatic test_ack_at_expiry();
    drive_setup(13'h044, 1'b0, '0, 4'b0000);
    step();
    penable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin ack = 1'b1; rerr = 1'b1; rrdata = 32'hCAFEF00D; end
      step();
    end
    vectors++;
    if ({pready, pslverr, prdata} !== {1'b1, 1'b1, 32'hCAFEF00D}) begin
      miscompares++; $display("FAIL ack_expiry: got pready=%b pslverr=%b prdata=%h want 1 1 cafef00d", pready, pslverr, prdata);
    end
    drive_idle();
    step();
    vectors++;
    if (rd_done !== 1'b0) begin miscompares++; $display("FAIL ack_expiry_rd_done: got %b want 0", rd_done); end
  endtask

  task automatic test_abort();
    drive_setup(13'h050, 1'b0, '0, 4'b0000);
    step();
    drive_idle();
    step();
    vectors++;
    if ({req, pready} !== 2'b10) begin miscompares++; $display("FAIL abort_hold_req: got req=%b pready=%b want 1 0", req, pready); end
    ack = 1'b1; rrdata = 32'h11111111;
    step();
    vectors++;
    if ({req, pready, prdata} !== {1'b0, 1'b0, 32'h0}) begin miscompares++; $display("FAIL abort_no_pready: got req=%b pready=%b prdata=%h want 0 0 0", req, pready, prdata); end
    drive_idle();
    step();
    vectors++;
    if ({rd_done, pready} !== 2'b00) begin miscompares++; $display("FAIL abort_no_rd_done: got rd_done=%b pready=%b want 0 0", rd_done, pready); end
    drive_setup(13'h054, 1'b0, '0, 4'b0000);
    step();
    vectors++;
    if ({req, raddr} !== {1'b1, 13'h054}) begin miscompares++; $display("FAIL abort_next_busy: got req=%b addr=%h want 1 054", req, raddr); end
    penable = 1'b1; ack = 1'b1; rrdata = 32'h22222222;
    step();
    vectors++;
    if ({pready, pslverr, prdata} !== {1'b1, 1'b0, 32'h22222222}) begin miscompares++; $display("FAIL abort_next_resp: got pready=%b pslverr=%b prdata=%h", pready, pslverr, prdata); end
    drive_idle();
    step();
  endtask

  task automatic test_back_to_back();
    drive_setup(13'h060, 1'b0, '0, 4'b0000);
    step();
    penable = 1'b1; ack = 1'b1; rrdata = 32'h0BADCAFE;
    step();
    // New setup presented while the bridge is still in RESP must not be taken.
    ack = 1'b0;
    drive_setup(13'h070, 1'b0, '0, 4'b0000);
    step();
    vectors++;
    if ({req, pready} !== 2'b00) begin miscompares++; $display("FAIL b2b_setup_in_resp: got req=%b pready=%b want 0 0", req, pready); end
    step();
    vectors++;
    if ({req, raddr} !== {1'b1, 13'h070}) begin miscompares++; $display("FAIL b2b_second_busy: got req=%b addr=%h want 1 070", req, raddr); end
    penable = 1'b1; ack = 1'b1; rrdata = 32'h76543210;
    step();
    vectors++;
    if ({pready, prdata} !== {1'b1, 32'h76543210}) begin miscompares++; $display("FAIL b2b_second_resp: got pready=%b prdata=%h", pready, prdata); end
    drive_idle();
    step();
  endtask

  task automatic test_reset_mid();
    drive_setup(13'h080, 1'b1, 32'hA5A5A5A5, 4'b1111);
    step();
    vectors++;
    if (req !== 1'b1) begin miscompares++; $display("FAIL rstmid_busy: got req=%b want 1", req); end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({req, we, raddr, rwdata, rbe, pready, prdata} !== '0) begin
      miscompares++; $display("FAIL rstmid_async: got req=%b we=%b addr=%h wdata=%h be=%b pready=%b", req, we, raddr, rwdata, rbe, pready);
    end
    step();
    rst = 1'b0;
    drive_idle();
    step();
    vectors++;
    if ({req, pready} !== 2'b00) begin miscompares++; $display("FAIL rstmid_idle: got req=%b pready=%b want 0 0", req, pready); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_addr_checks();
    test_timeout();
    test_ack_at_expiry();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
